// File: rtl/board_io_pkg.sv
// board_io_pkg
//   Shared constants for the board I/O controller:
//     HEX_SEG     - active-low hex-to-segment glyphs, bit order {g,f,e,d,c,b,a}
//     SEG_BLANK   - all segments off (7'h7F)
//     nibble_count(data_w) - number of hex digits needed for a data_w-bit word
package board_io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index = hex value 0..F. A segment is lit when its bit is 0.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic int nibble_count(input int data_w);
    return data_w / 4;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Synchronises a raw push-button level, accepts a level change only after
//   it has been stable for DEBOUNCE_CYCLES consecutive clocks, and emits a
//   one-cycle pulse on each accepted press (debounced 0 -> 1).
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   btn    - raw, unsynchronised button level (pressed = 1)
//   pulse  - one-cycle strobe per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // NOTE: every flop here uses <= so all of them sample pre-edge values;
  // blocking assignments would collapse the synchroniser chain into one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= level & ~level_q;

      // Any sample agreeing with the accepted level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
//   Board-side I/O controller: debounces the continue button into a run
//   pulse and scans a DATA_W-bit debug word across a multiplexed
//   NUM_DIGITS-digit seven-segment display. The shown value freezes on a
//   rising edge of halted and is released by the next accepted press; the
//   frozen state is flagged on digit 0's decimal point.
// Build option:
//   BOARD_IO_LZ_BLANK_EN - blank leading-zero digits (digit 0 always shown).
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high reset
//   continue_btn - raw push-button level (pressed = 1)
//   halted       - CPU halted status, synchronous to clk
//   debug        - live debug word
//   cont_pulse   - one-cycle strobe per accepted press
//   SEG          - segment cathodes {g..a}, active-low
//   AN           - digit anodes, active-low one-hot
//   DP           - decimal point, active-low
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 8,
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  continue_btn,
  input  logic                  halted,
  input  logic [DATA_W-1:0]     debug,
  output logic                  cont_pulse,
  output logic [6:0]            SEG,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  DP
);

  localparam int NIB = nibble_count(DATA_W);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic              hold;
  logic              halted_q;
  logic              halted_rise;
  logic [DATA_W-1:0] disp_val;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;
  logic [6:0]        seg_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (continue_btn),
    .pulse (cont_pulse)
  );

  assign halted_rise = halted & ~halted_q;

  // Freeze control: disp_val still loads in the cycle hold is being set, so
  // the frozen value is the debug word seen alongside the halted edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
      hold     <= 1'b0;
      disp_val <= '0;
    end else begin
      halted_q <= halted;
      if (!hold) begin
        disp_val <= debug;
      end
      // A press takes priority over a coincident halted edge.
      if (cont_pulse) begin
        hold <= 1'b0;
      end else if (halted_rise) begin
        hold <= 1'b1;
      end
    end
  end

`ifdef BOARD_IO_LZ_BLANK_EN
  logic [IW-1:0] msd;
`endif

  // NOTE: every variable gets its default before any conditional update so
  // this block stays purely combinational (no inferred latch).
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib = disp_val[4*i +: 4];
      end
    end
    seg_next = HEX_SEG[nib];
`ifdef BOARD_IO_LZ_BLANK_EN
    msd = '0;
    for (int i = 0; i < NIB; i++) begin
      if (disp_val[4*i +: 4] != 4'h0) begin
        msd = IW'(i);
      end
    end
    if (idx > msd) begin
      seg_next = SEG_BLANK;
    end
`endif
  end

  // Scanner: prescaler sets the per-digit dwell; display pins are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      SEG   <= SEG_BLANK;
      AN    <= '1;
      DP    <= 1'b1;
    end else begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      SEG <= seg_next;
      AN  <= ~(NUM_DIGITS'(1) << idx);
      DP  <= ~((idx == '0) && hold);
    end
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board-side I/O controller between the CPU core and the FPGA board. It debounces the raw continue push-button into a single-cycle run pulse and scans a DATA_W-bit debug word onto a NUM_DIGITS-digit multiplexed seven-segment display. It freezes the shown value when the CPU halts and marks the frozen state on the decimal point. It replaces the fixed 32-bit/8-digit display path and gives the core a clean, glitch-free continue strobe.

## Interface
- DATA_W, 32: debug word width; must be a multiple of 4.
- NUM_DIGITS, 8: number of display digits; must be ≥ DATA_W/4.
- REFRESH_DIV, 100000: clk cycles each digit is driven; must be ≥ 1.
- DEBOUNCE_CYCLES, 1000000: stable cycles required to accept a button level change; must be ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- continue_btn  in  1  raw, unsynchronised push-button level; pressed = 1.
- halted  in  1  CPU halted status, synchronous to clk.
- debug  in  DATA_W  live debug word from the CPU.
- cont_pulse  out  1  one-cycle strobe per accepted button press.
- SEG  out  7  segment cathodes a..g; active-low.
- AN  out  NUM_DIGITS  digit anodes; active-low, one-hot when driven.
- DP  out  1  decimal point; active-low.

## Operation
- Button path: 2-flop synchroniser, then a counter that must see the synchronised level differ from the debounced level for DEBOUNCE_CYCLES consecutive cycles. On that count, the debounced level flips and the counter clears. Any intermediate bounce back clears the counter.
- cont_pulse asserts for exactly one cycle on each 0→1 transition of the debounced level. Release produces no pulse.
- Display register disp_val (DATA_W): loads debug every cycle while hold = 0.
- hold sets on the rising edge of halted (halted = 1, previous halted = 0). disp_val then retains the debug value sampled in that same cycle.
- hold clears on cont_pulse. If cont_pulse and the halted rising edge coincide, cont_pulse wins: hold = 0 and disp_val keeps tracking debug.
- Scanner: a prescaler counts 0..REFRESH_DIV-1. At terminal count, digit index idx advances from 0 to NUM_DIGITS-1 and wraps to 0.
- Digit idx shows nibble disp_val[4·idx+3:4·idx] as hex 0-F. Digits with idx ≥ DATA_W/4 show 0.
- DP = 0 only when idx = 0 and hold = 1; otherwise DP = 1.

## Timing
- Reset values: cont_pulse=0, SEG=7'h7F, AN=all ones, DP=1, disp_val=0, hold=0, idx=0, prescaler=0, debounced level=0, debounce counter=0.
- Press latency: a clean press seen at clk edge N gives cont_pulse high in cycle N+2+DEBOUNCE_CYCLES (2 sync + count + edge register).
- SEG, AN and DP are registered, one cycle after idx or disp_val change.
- With REFRESH_DIV=1, idx advances every cycle.
- Reset mid-debounce discards the count. A button held through reset release yields exactly one pulse once debounce completes.
- halted held high does not re-arm hold after cont_pulse. Only a new 0→1 edge sets hold.

## Configuration
- BOARD_IO_LZ_BLANK_EN defined: digits above the most significant non-zero nibble of disp_val are blanked (SEG=7'h7F, AN still scanned). Digit 0 is always shown, so value 0 displays "0".
- Undefined: every digit shows its nibble, including leading zeros.

## Structure
- Package board_io_pkg holds:
  - the 16-entry active-low hex-to-segment constant table;
  - the SEG_BLANK constant (7'h7F);
  - a localparam helper for nibble count (DATA_W/4).
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES) contains the synchroniser, counter, debounced level and rising-edge pulse.
- Scanner and hold logic stay in the top module.

## Test plan
- Reset asserted mid-scan → SEG=7'h7F, AN=8'hFF, DP=1, cont_pulse=0 immediately, without waiting for a clock edge.
- DEBOUNCE_CYCLES=4, button bounces 1-0-1-1-1-1-1 → exactly one cont_pulse, 2+4+1 cycles after the last rising bounce; no pulse on release.
- REFRESH_DIV=2, debug=32'h1234ABCD, halted=0 → AN walks FE,FD,…,7F and wraps, changing every 2 cycles. SEG shows D,C,B,A,4,3,2,1 in step with AN.
- debug=32'h00000005 with halted rising, then debug changes to 32'hFFFFFFFF → display stays 0x00000005 and DP is low on digit 0. After a press, the display shows FFFFFFFF and DP is high.
- halted rising edge and cont_pulse in the same cycle → hold stays 0 and the display tracks debug.
- BOARD_IO_LZ_BLANK_EN defined, debug=32'h00000A00 → digits 3-7 blank, digits 0-2 show 0,0,A. With debug=0, only digit 0 shows "0".
